fp_div_seq: RTL and testbench

Sequential IEEE754 single-precision divider, result = A / B, computing one quotient bit per clock by restoring division.
It is the inverse-operation companion to the team's sequential shift-add multiplier and sits beside it in the calculator datapath.
A start/busy/done handshake lets the calculator control FSM launch an operation and collect the result.
Mantissa is truncated (no rounding), denormals are flushed to zero, and overflow/underflow flags use the same exponent convention as the multiplier.

---
 rtl/fp_div_seq.sv | 196 +++++++++++++++++++
 tb/tb_fp_div_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Sequential IEEE754 single-precision divider (A / B), one quotient bit per clock
// by restoring division; truncating, denormals flushed to zero, start/busy/done handshake.
module fp_div_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SPEC, CALC, NORM} state_t;

    state_t      state_q, state_d;
    logic [30:0] a_q, a_d;
    logic [30:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic [24:0] rem_q, rem_d;
    logic [23:0] dvs_q, dvs_d;
    logic [24:0] quo_q, quo_d;
    logic [9:0]  exp_q, exp_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        dz_q, dz_d;
    logic        done_q, done_d;

    // Operand classification on the live inputs (launch decision) and captured copies (SPEC).
    logic in_special;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    assign in_special = (A[30:23] == 8'h00) || (A[30:23] == 8'hFF) ||
                        (B[30:23] == 8'h00) || (B[30:23] == 8'hFF);

    assign a_zero = (a_q[30:23] == 8'h00);
    assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_zero = (b_q[30:23] == 8'h00);
    assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);

    logic [24:0] rem_diff;
    logic [9:0]  t_exp;
    logic [22:0] frac;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        rem_diff = rem_q - {1'b0, dvs_q};
        t_exp    = 10'd0;
        frac     = 23'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = A[30:0];
                    b_d    = B[30:0];
                    sign_d = A[31] ^ B[31];
                    rem_d  = {2'b01, A[22:0]};
                    dvs_d  = {1'b1, B[22:0]};
                    quo_d  = 25'd0;
                    exp_d  = {2'b00, A[30:23]} - {2'b00, B[30:23]};
                    if (in_special) begin
                        state_d = SPEC;
                    end else begin
                        state_d = CALC;
                        cnt_d   = 5'd25;
                    end
                end
            end

            CALC: begin
                // Bit 24 of the partial remainder is only ever set when R >= D,
                // so dropping it on the shift loses nothing.
                if (rem_q >= {1'b0, dvs_q}) begin
                    rem_d = {rem_diff[23:0], 1'b0};
                    quo_d = {quo_q[23:0], 1'b1};
                end else begin
                    rem_d = {rem_q[23:0], 1'b0};
                    quo_d = {quo_q[23:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_d == 5'd0) begin
                    state_d = NORM;
                end
            end

            NORM: begin
                if (quo_q[24]) begin
                    frac  = quo_q[23:1];
                    t_exp = exp_q + 10'd127;
                end else begin
                    frac  = quo_q[22:0];
                    t_exp = exp_q + 10'd126;
                end
                ovf_d = 1'b0;
                unf_d = 1'b0;
                dz_d  = 1'b0;
                if (!t_exp[9] && (t_exp[8:0] >= 9'd255)) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (t_exp[9] || (t_exp == 10'd0)) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, t_exp[7:0], frac};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            SPEC: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                dz_d  = 1'b0;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_d = 32'h7FC0_0000;
                end else if (a_inf) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                end else if (b_zero) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    dz_d     = 1'b1;
                end else begin
                    // Only A==0 or B==inf can remain here.
                    result_d = {sign_q, 31'd0};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            a_q      <= 31'd0;
            b_q      <= 31'd0;
            sign_q   <= 1'b0;
            rem_q    <= 25'd0;
            dvs_q    <= 24'd0;
            quo_q    <= 25'd0;
            exp_q    <= 10'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

    assign result      = result_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign div_by_zero = dz_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: expectations queued at launch, compared when done pulses.
module tb_fp_div_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] result;
    logic        overflow, underflow, div_by_zero, busy, done;

    fp_div_seq dut (
        .CLK(CLK), .RST(RST), .start(start), .A(A), .B(B),
        .result(result), .overflow(overflow), .underflow(underflow),
        .div_by_zero(div_by_zero), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;   // {overflow, underflow, div_by_zero}
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Scoreboard: each done pulse retires the oldest queued expectation.
    always @(negedge CLK) begin
        if (RST === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cyc=%0d result=%h", cyc, result);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (result !== mon_e.res) begin
                    failures++;
                    $display("FAIL %s result got=%h exp=%h", mon_e.name, result, mon_e.res);
                end
                checks++;
                if ({overflow, underflow, div_by_zero} !== mon_e.flags) begin
                    failures++;
                    $display("FAIL %s flags(ov,un,dz) got=%b exp=%b", mon_e.name,
                             {overflow, underflow, div_by_zero}, mon_e.flags);
                end
                checks++;
                if (cyc !== mon_e.due) begin
                    failures++;
                    $display("FAIL %s latency done_cycle got=%0d exp=%0d", mon_e.name, cyc, mon_e.due);
                end
                $display("txn %s result=%h flags=%b cyc=%0d", mon_e.name, result,
                         {overflow, underflow, div_by_zero}, cyc);
            end
        end
    end

    // Launch one operation (DUT idle), queue its expectation, then scramble the inputs.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                          input logic [2:0] flags, input int lat, input string name);
        @(negedge CLK);
        A = a; B = b; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        sb.push_back('{res, flags, cyc + lat, name});
        A = $urandom; B = $urandom;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        ok = (sb.size() == 0);
        if (!ok) sb.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if ({result, overflow, underflow, div_by_zero, busy, done} !== 37'd0) begin
            failures++;
            $display("FAIL reset_state got=%h/%b exp=0", result,
                     {overflow, underflow, div_by_zero, busy, done});
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy/done got=%b%b exp=00", busy, done);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int bad = 0;
        launch(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 26, "div_6_2");
        for (int i = 0; i < 26; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge CLK);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_window bad_cycles got=%0d exp=0", bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_done got=%b exp=0", busy);
        end
        drain(ok);
        launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 26, "div_1_3");
        drain(ok);
        launch(32'hC0F00000, 32'h40200000, 32'hC0400000, 3'b000, 26, "div_m7p5_2p5");
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_drain pending got=timeout exp=empty");
        end
    endtask

    task automatic test_range();
        bit ok;
        launch(32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 26, "overflow");
        drain(ok);
        launch(32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 26, "underflow");
        drain(ok);
        launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 26, "flags_clear");
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL range_drain pending got=timeout exp=empty");
        end
    endtask

    task automatic test_special();
        bit ok;
        launch(32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 1, "one_div_zero");
        launch(32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001, 1, "neg_div_zero");
        launch(32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 1, "zero_div_zero");
        launch(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b000, 1, "nan_a");
        launch(32'h3F800000, 32'h7F800001, 32'h7FC00000, 3'b000, 1, "nan_b");
        launch(32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000, 1, "inf_div_inf");
        launch(32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 1, "inf_div_m2");
        launch(32'h00000000, 32'hBF800000, 32'h80000000, 3'b000, 1, "zero_div_m1");
        launch(32'h3F800000, 32'h7F800000, 32'h00000000, 3'b000, 1, "one_div_inf");
        launch(32'h00400000, 32'h3F800000, 32'h00000000, 3'b000, 1, "denorm_flush");
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL special_drain pending got=timeout exp=empty");
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n = 0;
        launch(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 26, "busy_ignore");
        repeat (9) @(negedge CLK);
        A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_done got=timeout exp=pulse");
        end
        // Launch in the done cycle itself.
        A = 32'hC0F00000; B = 32'h40200000; start = 1'b1;
        sb.push_back('{32'hC0400000, 3'b000, cyc + 27, "done_cycle_start"});
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL done_cycle_accept busy/done got=%b%b exp=10", busy, done);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_drain pending got=timeout exp=empty");
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        @(negedge CLK);
        A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (11) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if ({result, overflow, underflow, div_by_zero, busy, done} !== 37'd0) begin
            failures++;
            $display("FAIL abort_reset got=%h/%b exp=0", result,
                     {overflow, underflow, div_by_zero, busy, done});
        end
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (30) @(negedge CLK);
        launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 26, "after_abort");
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_drain pending got=timeout exp=empty");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_special();
        test_back_to_back();
        test_reset_abort();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
